// File: rtl/usb_bus_state_mon.sv
// ---------------------------------------------------------------------------
// usb_bus_state_mon
//
// Follows the full-speed USB bus state: ACTIVE, SUSPEND (long idle J),
// RESUME (filtered K from the host) and RESET (driven by usb_reset_det).
// Emits a one-cycle strobe when SUSPEND, RESUME or RESET is entered so the
// device core can gate clocks or reinitialise its endpoints.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   usb_p_rx     D+ receive pin, asynchronous to clk
//   usb_n_rx     D- receive pin, asynchronous to clk
//   usb_reset    bus-reset level from usb_reset_det, already in clk domain
//   state        0=ACTIVE 1=SUSPEND 2=RESUME 3=RESET
//   suspend      high while state is SUSPEND
//   suspend_evt  one-cycle strobe on entry to SUSPEND
//   resume_evt   one-cycle strobe on entry to RESUME
//   reset_evt    one-cycle strobe on entry to RESET
// ---------------------------------------------------------------------------
module usb_bus_state_mon #(
  parameter int unsigned IN_CLK_MHZ      = 12,
  parameter int unsigned SUSPEND_US      = 3000,
  parameter int unsigned K_FILTER_CYCLES = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  input  logic       usb_reset,
  output logic [1:0] state,
  output logic       suspend,
  output logic       suspend_evt,
  output logic       resume_evt,
  output logic       reset_evt
);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_SUSPEND = 2'd1,
    ST_RESUME  = 2'd2,
    ST_RESET   = 2'd3
  } state_e;

  localparam int unsigned SUSPEND_CYCLES = SUSPEND_US * IN_CLK_MHZ;
  // Last count value before the terminal sample; the terminal sample itself
  // causes the transition instead of incrementing.
  localparam logic [23:0] IDLE_LAST = 24'(SUSPEND_CYCLES - 1);
  localparam logic [23:0] K_LAST    = 24'(K_FILTER_CYCLES - 1);
  localparam logic [23:0] CNT_MAX   = 24'hFF_FFFF;

  // Saturating increment: counters stick at all-ones rather than wrapping.
  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 24'd1;
    end
  endfunction

  logic   p_meta_q, p_sync_q, n_meta_q, n_sync_q;
  logic   bus_j, bus_k;
  state_e state_q, state_d;
  logic [23:0] idle_cnt_q, idle_cnt_d;
  logic [23:0] k_cnt_q, k_cnt_d;
  logic   suspend_q, suspend_d;
  logic   suspend_evt_q, suspend_evt_d;
  logic   resume_evt_q, resume_evt_d;
  logic   reset_evt_q, reset_evt_d;

  // Two-flop synchronisers for the asynchronous line receivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_meta_q <= 1'b0;
      p_sync_q <= 1'b0;
      n_meta_q <= 1'b0;
      n_sync_q <= 1'b0;
    end else begin
      p_meta_q <= usb_p_rx;
      p_sync_q <= p_meta_q;
      n_meta_q <= usb_n_rx;
      n_sync_q <= n_meta_q;
    end
  end

  // SE0 and SE1 are both "neither J nor K"; SE1 therefore clears both counters.
  assign bus_j = p_sync_q & ~n_sync_q;
  assign bus_k = ~p_sync_q & n_sync_q;

  // Next-state, counter and strobe logic; usb_reset overrides everything.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = 24'd0;
    k_cnt_d    = 24'd0;
    if (usb_reset) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (bus_j) begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_d = ST_SUSPEND;
            end else begin
              idle_cnt_d = sat_inc(idle_cnt_q);
            end
          end else begin
            idle_cnt_d = 24'd0;
          end
        end
        ST_SUSPEND: begin
          if (bus_k) begin
            if (k_cnt_q == K_LAST) begin
              state_d = ST_RESUME;
            end else begin
              k_cnt_d = sat_inc(k_cnt_q);
            end
          end else begin
            k_cnt_d = 24'd0;
          end
        end
        ST_RESUME: begin
          // K and the closing SE0 hold; only a J ends the resume.
          if (bus_j) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_RESUME;
          end
        end
        ST_RESET: begin
          state_d = ST_ACTIVE;
        end
        default: begin
          state_d = ST_ACTIVE;
        end
      endcase
    end
    // Strobes fire only on a genuine entry, so holding RESET gives one pulse.
    suspend_d     = (state_d == ST_SUSPEND);
    suspend_evt_d = (state_d == ST_SUSPEND) && (state_q != ST_SUSPEND);
    resume_evt_d  = (state_d == ST_RESUME)  && (state_q != ST_RESUME);
    reset_evt_d   = (state_d == ST_RESET)   && (state_q != ST_RESET);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_ACTIVE;
      idle_cnt_q    <= 24'd0;
      k_cnt_q       <= 24'd0;
      suspend_q     <= 1'b0;
      suspend_evt_q <= 1'b0;
      resume_evt_q  <= 1'b0;
      reset_evt_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      k_cnt_q       <= k_cnt_d;
      suspend_q     <= suspend_d;
      suspend_evt_q <= suspend_evt_d;
      resume_evt_q  <= resume_evt_d;
      reset_evt_q   <= reset_evt_d;
    end
  end

  assign state       = state_q;
  assign suspend     = suspend_q;
  assign suspend_evt = suspend_evt_q;
  assign resume_evt  = resume_evt_q;
  assign reset_evt   = reset_evt_q;

endmodule
